// File: rtl/register_bus_reader.sv
// Reads one register of a shared tri-state bus by pulsing its chip select, waiting
// SettleCycles enabled cycles, and capturing the bus. Optional macro: BUS_TURNAROUND_EN.
module register_bus_reader #(
  parameter int NrOfBits     = 8,
  parameter int AddrBits     = 2,
  parameter int SettleCycles = 1,
  localparam int NrOfRegs    = 2**AddrBits
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                ReqValid,
  input  logic [AddrBits-1:0] ReqAddr,
  output logic                ReqReady,
  output logic [NrOfRegs-1:0] cs,
  input  logic [NrOfBits-1:0] BusData,
  output logic                RspValid,
  output logic [NrOfBits-1:0] RspData,
  input  logic                RspReady,
  output logic                Busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] SELECT     = 2'd1;
  localparam logic [1:0] RESPOND    = 2'd2;
`ifdef BUS_TURNAROUND_EN
  localparam logic [1:0] TURNAROUND = 2'd3;
`endif

  localparam logic [3:0]          SETTLE  = 4'(SettleCycles);
  localparam logic [NrOfRegs-1:0] ONE_HOT = {{(NrOfRegs-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [3:0]          count;
  logic [AddrBits-1:0] addr_q;
  logic [NrOfRegs-1:0] cs_q;
  logic [NrOfBits-1:0] data_q;
  logic                en;

  assign en = ClockEnable & Tick;

  // NOTE: chip selects are reset asynchronously so a reset mid-read frees the bus
  // immediately, without waiting for a clock edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      count  <= '0;
      addr_q <= '0;
      cs_q   <= '1;
      data_q <= '0;
    end else if (en) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so case arms may read count/addr_q while also updating them.
      case (state)
        IDLE: begin
          if (ReqValid) begin
            addr_q <= ReqAddr;
            count  <= SETTLE;
            cs_q   <= ~(ONE_HOT << ReqAddr);
            state  <= SELECT;
          end
        end
        SELECT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            data_q <= BusData;
            cs_q   <= '1;
            state  <= RESPOND;
          end else begin
            cs_q <= ~(ONE_HOT << addr_q);
          end
        end
        RESPOND: begin
          if (RspReady) begin
`ifdef BUS_TURNAROUND_EN
            state <= TURNAROUND;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef BUS_TURNAROUND_EN
        TURNAROUND: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign cs       = cs_q;
  assign RspData  = data_q;
  assign RspValid = (state == RESPOND);
  assign ReqReady = (state == IDLE);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_register_bus_reader.sv
// Directed bench for register_bus_reader: one default instance and one with
// SettleCycles = 3; turnaround expectations follow BUS_TURNAROUND_EN.
module tb_register_bus_reader;

  logic       Clock = 1'b0;
  logic       Reset;

  logic       ce, tick, req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [1:0] req_addr;
  logic [3:0] cs;
  logic [7:0] bus_data, rsp_data;

  logic       ce3, tick3, req_valid3, req_ready3, rsp_valid3, rsp_ready3, busy3;
  logic [1:0] req_addr3;
  logic [3:0] cs3;
  logic [7:0] bus_data3, rsp_data3;

  logic [7:0] regs  [4];
  logic [7:0] regs3 [4];

  int tests  = 0;
  int failed = 0;

  always #5 Clock = ~Clock;

  // Tri-state bus model: the register whose chip select is low drives the bus.
  always_comb begin
    bus_data = 'z;
    for (int i = 0; i < 4; i++) if (cs[i] == 1'b0) bus_data = regs[i];
  end
  always_comb begin
    bus_data3 = 'z;
    for (int i = 0; i < 4; i++) if (cs3[i] == 1'b0) bus_data3 = regs3[i];
  end

  register_bus_reader dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ce), .Tick(tick),
    .ReqValid(req_valid), .ReqAddr(req_addr), .ReqReady(req_ready),
    .cs(cs), .BusData(bus_data), .RspValid(rsp_valid), .RspData(rsp_data),
    .RspReady(rsp_ready), .Busy(busy)
  );

  register_bus_reader #(.SettleCycles(3)) dut3 (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ce3), .Tick(tick3),
    .ReqValid(req_valid3), .ReqAddr(req_addr3), .ReqReady(req_ready3),
    .cs(cs3), .BusData(bus_data3), .RspValid(rsp_valid3), .RspData(rsp_data3),
    .RspReady(rsp_ready3), .Busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b0;
    ce = 1'b0; tick = 1'b0; req_valid = 1'b0; req_addr = 2'd0; rsp_ready = 1'b0;
    ce3 = 1'b0; tick3 = 1'b0; req_valid3 = 1'b0; req_addr3 = 2'd0; rsp_ready3 = 1'b0;
    regs  = '{8'h77, 8'h3C, 8'hA5, 8'hC3};
    regs3 = '{8'h11, 8'h22, 8'h33, 8'h5A};

    // Reset held with clock running
    @(negedge Clock);
    check("rst_cs",        cs,        4'hF);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  8'h00);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst_cs3",       cs3,       4'hF);
    step();
    check("rst_hold_cs",        cs,        4'hF);
    check("rst_hold_req_ready", req_ready, 1'b1);

    Reset = 1'b1;
    ce = 1'b1; tick = 1'b1; ce3 = 1'b1; tick3 = 1'b1;
    step();
    check("post_rst_req_ready", req_ready, 1'b1);
    check("post_rst_cs",        cs,        4'hF);
    check("post_rst_rsp_valid", rsp_valid, 1'b0);
    check("post_rst_rsp_data",  rsp_data,  8'h00);

    // Default read of register 2
    req_valid = 1'b1; req_addr = 2'd2;
    step();
    check("sel_cs",        cs,        4'b1011);
    check("sel_req_ready", req_ready, 1'b0);
    check("sel_busy",      busy,      1'b1);
    check("sel_rsp_valid", rsp_valid, 1'b0);
    req_addr = 2'd1;
    step();
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_data",  rsp_data,  8'hA5);
    check("rsp_cs",    cs,        4'hF);

    // Back-pressure with a pending request for another address
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_data",  rsp_data,  8'hA5);
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_cs",        cs,        4'hF);
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
`ifdef BUS_TURNAROUND_EN
    check("ta_rsp_valid", rsp_valid, 1'b0);
    check("ta_req_ready", req_ready, 1'b0);
    check("ta_busy",      busy,      1'b1);
    check("ta_cs",        cs,        4'hF);
    step();
`endif
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_req_ready", req_ready, 1'b1);
    check("retain_rsp_data", rsp_data, 8'hA5);
    step();
    check("b2b_cs", cs, 4'b1101);
    req_valid = 1'b0;
    step();
    check("b2b_rsp_valid", rsp_valid, 1'b1);
    check("b2b_rsp_data",  rsp_data,  8'h3C);
    rsp_ready = 1'b1;
    step();
    check("b2b_done_rsp_valid", rsp_valid, 1'b0);
`ifdef BUS_TURNAROUND_EN
    check("b2b_ta_req_ready", req_ready, 1'b0);
    step();
`endif
    check("b2b_idle_req_ready", req_ready, 1'b1);

    // RspReady while idle has no effect
    step();
    check("idle_ready_req_ready", req_ready, 1'b1);
    check("idle_ready_rsp_valid", rsp_valid, 1'b0);
    check("idle_ready_rsp_data",  rsp_data,  8'h3C);
    rsp_ready = 1'b0;

    // SettleCycles = 3 with Tick every other cycle
    req_valid3 = 1'b1; req_addr3 = 2'd3;
    step();
    check("s3_accept_cs",   cs3,   4'b0111);
    check("s3_accept_busy", busy3, 1'b1);
    req_valid3 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick3 = 1'b0;
      step();
      check("s3_frozen_cs",        cs3,        4'b0111);
      check("s3_frozen_rsp_valid", rsp_valid3, 1'b0);
      tick3 = 1'b1;
      step();
      if (k < 3) begin
        check("s3_sel_cs",        cs3,        4'b0111);
        check("s3_sel_rsp_valid", rsp_valid3, 1'b0);
      end else begin
        check("s3_rsp_valid", rsp_valid3, 1'b1);
        check("s3_rsp_data",  rsp_data3,  8'h5A);
        check("s3_rsp_cs",    cs3,        4'hF);
      end
    end
    tick3 = 1'b0; rsp_ready3 = 1'b1;
    step();
    check("s3_hold_rsp_valid", rsp_valid3, 1'b1);
    tick3 = 1'b1;
    step();
    check("s3_done_rsp_valid", rsp_valid3, 1'b0);
    check("s3_done_rsp_data",  rsp_data3,  8'h5A);
`ifdef BUS_TURNAROUND_EN
    check("s3_ta_req_ready", req_ready3, 1'b0);
    step();
`endif
    check("s3_idle_req_ready", req_ready3, 1'b1);
    rsp_ready3 = 1'b0;

    // Reset pulsed in the middle of SELECT
    req_valid = 1'b1; req_addr = 2'd0;
    step();
    check("abort_sel_cs", cs, 4'b1110);
    req_valid = 1'b0; tick = 1'b0;
    step();
    check("abort_frozen_cs", cs, 4'b1110);
    #2 Reset = 1'b0;
    #1;
    check("abort_cs_async",  cs,        4'hF);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_busy",      busy,      1'b0);
    check("abort_rsp_data",  rsp_data,  8'h00);
    @(negedge Clock);
    check("abort_hold_rsp_valid", rsp_valid, 1'b0);
    Reset = 1'b1; tick = 1'b1; req_valid = 1'b1; req_addr = 2'd0;
    step();
    check("recover_cs",        cs,        4'b1110);
    check("recover_rsp_valid", rsp_valid, 1'b0);
    req_valid = 1'b0;
    step();
    check("recover_rsp_valid2", rsp_valid, 1'b1);
    check("recover_rsp_data",   rsp_data,  8'h77);
    rsp_ready = 1'b1;
    step();
    check("recover_done", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/register_bus_reader.md
REGISTER_BUS_READER -- requirements
Module: register_bus_reader

Interface
REQ-001 Parameter NrOfBits, default 8: width of the shared register bus and of the response data.
REQ-002 Parameter AddrBits, default 2: register-select address width; NrOfRegs = 2**AddrBits.
REQ-003 Parameter SettleCycles, default 1, legal range 1..15: number of enabled cycles a chip select is held before the bus is sampled.
REQ-004 Clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-low.
REQ-006 ClockEnable  input  1  functional enable; ANDed with Tick.
REQ-007 Tick  input  1  clock-gating tick; an "enabled cycle" is a rising Clock edge with ClockEnable&Tick = 1.
REQ-008 ReqValid  input  1  read request present.
REQ-009 ReqAddr  input  AddrBits  index of the bus register to read.
REQ-010 ReqReady  output  1  block can accept a request.
REQ-011 cs  output  NrOfRegs  per-register chip select; 1 = register output high-Z, 0 = register drives bus.
REQ-012 BusData  input  NrOfBits  shared tri-state bus from the register outputs.
REQ-013 RspValid  output  1  RspData holds a completed read.
REQ-014 RspData  output  NrOfBits  captured register value.
REQ-015 RspReady  input  1  consumer accepts the response.
REQ-016 Busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SELECT, RESPOND, plus TURNAROUND when configured (REQ-031); state and counter SHALL advance only on enabled cycles and hold otherwise.
REQ-018 ReqReady SHALL be 1 only in IDLE.
REQ-019 On an enabled cycle in IDLE with ReqValid = 1: latch ReqAddr, load the settle counter with SettleCycles, go to SELECT.
REQ-020 In SELECT, cs[latched addr] SHALL be 0 and all other cs bits 1; the counter decrements each enabled cycle.
REQ-021 On the enabled cycle where the counter equals 1 in SELECT: capture BusData into RspData, drive all cs to 1 from the next cycle, go to RESPOND.
REQ-022 All cs bits SHALL be register outputs, glitch-free, with at most one bit 0 at any time.
REQ-023 In RESPOND, RspValid SHALL be 1 and RspData stable until an enabled cycle with RspReady = 1; then go to IDLE (or TURNAROUND).
REQ-024 Latency: request-accept edge to RspValid = 1 SHALL be SettleCycles+1 enabled cycles (2 for the default).
REQ-025 A ReqValid asserted during SELECT or RESPOND SHALL be ignored, not queued; ReqAddr changes after acceptance SHALL not affect the read in progress.
REQ-026 RspReady = 1 outside RESPOND SHALL have no effect.
REQ-027 RspData SHALL retain the last captured value after RspValid falls, until the next capture.

Reset
REQ-028 While Reset = 0, asynchronously: state = IDLE, cs = all ones, RspValid = 0, RspData = 0, counter = 0, latched address = 0, ReqReady = 1, Busy = 0.
REQ-029 Reset asserted during SELECT SHALL release the bus (all cs = 1) without waiting for a Clock edge; the aborted read SHALL produce no response.
REQ-030 The first enabled cycle after Reset deasserts SHALL be able to accept a request.

Configuration
REQ-031 Macro BUS_TURNAROUND_EN: when defined, leaving RESPOND SHALL enter TURNAROUND for exactly one enabled cycle (cs all ones, ReqReady = 0, Busy = 1) before IDLE; when undefined, RESPOND SHALL go directly to IDLE, TURNAROUND SHALL not exist, and no turnaround logic SHALL be present.

Verification
REQ-032 Reset low, Clock running, then released -> cs = all ones, RspValid = 0, RspData = 0x00, ReqReady = 1 during and after reset.
REQ-033 Defaults, Tick = ClockEnable = 1, request addr 2 with BusData = 0xA5 while cs = 4'b1011 -> RspValid = 1 two edges after accept, RspData = 0xA5, cs back to 4'b1111.
REQ-034 SettleCycles = 3, Tick high every other cycle -> cs held low for 3 enabled cycles, RspValid after 4 enabled cycles, state frozen on non-tick edges.
REQ-035 RspReady held 0 for 5 cycles while ReqValid = 1 with a new address -> RspValid and RspData unchanged, second request accepted only after return to IDLE.
REQ-036 Reset pulsed low mid-SELECT -> cs = all ones immediately, no RspValid pulse, next request completes normally.
REQ-037 With BUS_TURNAROUND_EN, back-to-back requests -> exactly one enabled cycle with cs all ones and ReqReady = 0 between RspReady handshake and next accept; without it, accept possible on the edge after the handshake.
